muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative unsigned multiply/divide sequencer for MULTU/DIVU. It sits beside the EX stage and borrows the shared 32-bit ALU for 32 iterations, driving its operands and control code: add (4'b0010) for shift-add multiply and subtract (4'b0110) for restoring divide. It holds the 64-bit result in HI/LO and raises `busy` so the pipeline stalls MFHI/MFLO and further mult/div issue.

## Interface
Parameters: none. Width fixed at 32, iteration count fixed at 32.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  1  0 = MULTU, 1 = DIVU; sampled with `start`.
- `rs_val`  in  32  multiplicand or dividend.
- `rt_val`  in  32  multiplier or divisor.
- `alu_r`  in  32  result returned by the shared ALU.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_ctl`  out  4  ALU control code.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; HI/LO are valid.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.
- `div_zero`  out  1  sticky flag; set by DIVU with `rt_val == 0`, cleared by the next accepted start.

## Operation
- States: IDLE, RUN, DONE. A 5-bit iteration counter `cnt` and a 32-bit operand register `opd` (latched `rt_val`).
- IDLE with `start = 1`:
  - Latch `op`, `opd <= rt_val`, `cnt <= 0`, clear `div_zero`.
  - MULTU: `hi <= 0`, `lo <= rs_val`.
  - DIVU: `hi <= 0`, `lo <= rs_val`.
  - DIVU with `rt_val == 0`: go to DONE directly with `hi <= rs_val`, `lo <= 32'hFFFFFFFF`, `div_zero <= 1`. Otherwise go to RUN.
- RUN, MULTU, each cycle:
  - Drive `alu_a = hi`, `alu_b = opd`, `alu_ctl = 4'b0010`.
  - Carry is `c = (alu_r < hi)`, an unsigned compare.
  - If `lo[0]`: `hi <= {c, alu_r[31:1]}`, `lo <= {alu_r[0], lo[31:1]}`.
  - Else: `hi <= {1'b0, hi[31:1]}`, `lo <= {hi[0], lo[31:1]}`.
- RUN, DIVU, each cycle:
  - Shifted remainder is `s = {hi[30:0], lo[31]}`; overflow bit is `m = hi[31]`.
  - Drive `alu_a = s`, `alu_b = opd`, `alu_ctl = 4'b0110`.
  - If `m | (s >= opd)`: `hi <= alu_r`, `lo <= {lo[30:0], 1'b1}`.
  - Else: `hi <= s`, `lo <= {lo[30:0], 1'b0}`.
  - The subtraction is taken modulo 2^32, which is correct when `m = 1`.
- `cnt` increments every RUN cycle. The transition to DONE happens on the cycle where `cnt == 31` (the 32nd iteration).
- DONE: `done = 1` for exactly one cycle, then return to IDLE unconditionally. `start` is ignored in RUN and DONE and is not queued.
- Outside RUN, drive `alu_a = 0`, `alu_b = 0`, `alu_ctl = 4'b0010`. The EX-stage mux selects the controller's ALU inputs only while `busy && state == RUN`.
- HI/LO hold their value in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, `clrn = 0`):
  - state IDLE, `cnt = 0`, `opd = 0`.
  - `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, `div_zero = 0`.
  - ALU outputs at their idle values.
- Reset asserted mid-RUN aborts the operation immediately; no `done` pulse is produced.
- `start` is sampled at edge 0.
  - Normal operation: RUN occupies cycles 1–32, DONE is cycle 33, IDLE from cycle 34. `busy` is high in cycles 1–33.
  - Divide-by-zero: DONE is cycle 1 and `busy` is high for one cycle.
- The earliest next start is sampled at the edge ending cycle 34, i.e. in the first IDLE cycle.
- `hi`/`lo` are valid from the first cycle in which `done = 1`.
- ALU path: `alu_a/alu_b/alu_ctl` → `alu_r` → next-state logic is a single combinational loop through the ALU and must close within one cycle.

## Test plan
- MULTU 7 × 6 → `done` at cycle 33, `hi = 0`, `lo = 42`; `busy` high in cycles 1–33.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → `hi = 32'hFFFFFFFE`, `lo = 32'h00000001` (exercises carry out of the add).
- DIVU 100 / 7 → `lo = 14`, `hi = 2`. DIVU 32'hFFFFFFFF / 32'h80000001 → `lo = 1`, `hi = 32'h7FFFFFFE` (exercises `m = 1`).
- DIVU 5 / 0 → `done` at cycle 1, `hi = 5`, `lo = 32'hFFFFFFFF`, `div_zero = 1`. A following MULTU 2 × 3 clears `div_zero` and gives `lo = 6`.
- `start` pulsed at cycles 5 and 33 during a MULTU 3 × 4 → both ignored, result `lo = 12`. Back-to-back start in cycle 34 is accepted.
- `clrn` dropped at cycle 10 of a DIVU → all outputs 0 immediately, no `done` pulse. After release, DIVU 9 / 3 → `lo = 3`, `hi = 0`.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake, operand and result bundle between the EX stage and the
// iterative multiply/divide sequencer, including the borrowed ALU path.
interface muldiv_ctrl_if;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_r;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctl;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport master (
    output start, op, rs_val, rt_val, alu_r,
    input  alu_a, alu_b, alu_ctl, busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, alu_r,
    output alu_a, alu_b, alu_ctl, busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MULTU/DIVU sequencer: 32 shift-add or restoring-divide iterations on a
// shared ALU, with the 64-bit result kept in HI/LO.
module muldiv_ctrl (
  input  logic         clk,
  input  logic         clrn,
  muldiv_ctrl_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opd_q, opd_d;
  logic        op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic [31:0] alu_a_d, alu_b_d, shifted;
  logic [3:0]  alu_ctl_d;
  logic        carry, ovf;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opd_q   <= '0;
      op_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opd_q   <= opd_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Divide works on the remainder shifted left by one; the bit falling out
  // of HI means the true remainder already exceeds any 32-bit divisor.
  assign shifted = {hi_q[30:0], lo_q[31]};
  assign ovf     = hi_q[31];
  assign carry   = (bus.alu_r < hi_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opd_d     = opd_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_ctl_d = ALU_ADD;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          opd_d = bus.rt_val;
          cnt_d = '0;
          dz_d  = 1'b0;
          hi_d  = '0;
          lo_d  = bus.rs_val;
          if (bus.op && (bus.rt_val == '0)) begin
            hi_d    = bus.rs_val;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        cnt_d   = cnt_q + 5'd1;
        alu_b_d = opd_q;
        if (op_q) begin
          alu_a_d   = shifted;
          alu_ctl_d = ALU_SUB;
          if (ovf || (shifted >= opd_q)) begin
            hi_d = bus.alu_r;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = shifted;
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          alu_a_d   = hi_q;
          alu_ctl_d = ALU_ADD;
          if (lo_q[0]) begin
            hi_d = {carry, bus.alu_r[31:1]};
            lo_d = {bus.alu_r[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_a    = alu_a_d;
  assign bus.alu_b    = alu_b_d;
  assign bus.alu_ctl  = alu_ctl_d;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random MULTU/DIVU
// against plain-arithmetic results, with a behavioural add/sub ALU.
module tb_muldiv_ctrl;
  logic clk;
  logic clrn;
  int   n_checks;
  int   n_errors;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  assign bus.alu_r = (bus.alu_ctl == 4'b0110) ? (bus.alu_a - bus.alu_b)
                                              : (bus.alu_a + bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    if (!op) begin
      p = {32'd0, a} * {32'd0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  {63'd0, bus.busy}, 64'd0);
    check_eq({tag, "_done"},  {63'd0, bus.done}, 64'd0);
    check_eq({tag, "_alu_a"}, {32'd0, bus.alu_a}, 64'd0);
    check_eq({tag, "_alu_b"}, {32'd0, bus.alu_b}, 64'd0);
    check_eq({tag, "_alu_ctl"}, {60'd0, bus.alu_ctl}, 64'h2);
  endtask

  // Called at #1 after an edge; the start it drives is sampled at the next edge.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int inj1, input int inj2);
    logic [63:0] exp;
    int          cyc;
    int          exp_cyc;
    exp     = ref_result(op, a, b);
    exp_cyc = (op && b == 32'd0) ? 1 : 33;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    cyc = 1;
    forever begin
      if (cyc == inj1 || cyc == inj2) begin
        bus.start  = 1'b1;
        bus.op     = 1'b1;
        bus.rs_val = $urandom;
        bus.rt_val = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      check_eq("busy_run", {63'd0, bus.busy}, 64'd1);
      if (bus.done) break;
      if (cyc >= 60) begin
        check_eq("done_timeout", 64'(cyc), 64'(exp_cyc));
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("done_cycle", 64'(cyc), 64'(exp_cyc));
    check_eq("hilo", {bus.hi, bus.lo}, exp);
    check_eq("div_zero", {63'd0, bus.div_zero}, {63'd0, (op && b == 32'd0)});
    $display("op=%0d a=%0h b=%0h -> hi=%0h lo=%0h dz=%0d cyc=%0d",
             op, a, b, bus.hi, bus.lo, bus.div_zero, cyc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_idle_outputs("post");
    check_eq("hilo_hold", {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    clrn       = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("reset_dz", {63'd0, bus.div_zero}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    do_op(1'b0, 32'd7, 32'd6, 0, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(1'b1, 32'd100, 32'd7, 0, 0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
    do_op(1'b1, 32'd5, 32'd0, 0, 0);
    do_op(1'b0, 32'd2, 32'd3, 0, 0);
    do_op(1'b0, 32'd3, 32'd4, 5, 33);
    do_op(1'b0, 32'd11, 32'd13, 0, 0);

    // Abort a divide with reset partway through RUN.
    bus.start  = 1'b1;
    bus.op     = 1'b1;
    bus.rs_val = 32'd1000;
    bus.rt_val = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("pre_abort_busy", {63'd0, bus.busy}, 64'd1);
    clrn = 1'b0;
    #1;
    check_idle_outputs("abort");
    check_eq("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_done", {63'd0, bus.done}, 64'd0);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b1, 32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic        r_op;
      logic [31:0] r_a, r_b;
      r_op = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 255));
        2:       r_b = 32'h8000_0000 | $urandom;
        default: r_b = $urandom;
      endcase
      do_op(r_op, r_a, r_b, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
